// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types for the decode/execute boundary: the packed control
// bundle, its all-zero NOP value, and the result_src / alu_ctrl encodings.
package rv_pipe_pkg;

  localparam int unsigned REG_IDX_W = 5;

  // result_src encodings
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // alu_ctrl encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_ctrl;
    logic       alu_src;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection for the ID/EX boundary (purely combinational).
// Ports:
//   valid_e_i, result_src_e_i, rd_e_i : instruction currently held in EX
//   rs1_d_i, rs2_d_i                  : source indices of the decoding instruction
//   lu_hazard_o                       : EX load feeds a decode source
//   stall_f_o, stall_d_o              : hold PC and IF/ID while the hazard is up
module hazard_detect
  import rv_pipe_pkg::*;
(
  input  logic                 valid_e_i,
  input  logic [1:0]           result_src_e_i,
  input  logic [REG_IDX_W-1:0] rd_e_i,
  input  logic [REG_IDX_W-1:0] rs1_d_i,
  input  logic [REG_IDX_W-1:0] rs2_d_i,
  output logic                 lu_hazard_o,
  output logic                 stall_f_o,
  output logic                 stall_d_o
);

  // x0 never carries a dependency, and a bubble in EX produces nothing.
  assign lu_hazard_o = valid_e_i
                     & (result_src_e_i == RES_MEM)
                     & (rd_e_i != '0)
                     & ((rd_e_i == rs1_d_i) | (rd_e_i == rs2_d_i));

  assign stall_f_o = lu_hazard_o;
  assign stall_d_o = lu_hazard_o;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation, bubble insertion on
// hazard or branch flush, and a saturating bubble counter.
// Config macro: WB_BYPASS_EN -- when defined, writeback data is forwarded into
// the captured RD1/RD2 if the WB destination matches rs1_d/rs2_d.
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   flush_i                            : squash the instruction entering EX
//   rd1_d, rd2_d, rs1_d, rs2_d, rd_d,
//   pc_d, pc_plus4_d, imm_d, ctrl_d    : decode-stage instruction
//   rd_w, result_w, reg_write_w        : writeback port (bypass only)
//   *_e, valid_e                       : EX-stage registered instruction
//   stall_f, stall_d                   : load-use stall requests
//   bubble_cnt                         : saturating count of inserted bubbles
module id_ex_stage
  import rv_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic [XLEN-1:0]      rd1_d,
  input  logic [XLEN-1:0]      rd2_d,
  input  logic [REG_IDX_W-1:0] rs1_d,
  input  logic [REG_IDX_W-1:0] rs2_d,
  input  logic [REG_IDX_W-1:0] rd_d,
  input  logic [XLEN-1:0]      pc_d,
  input  logic [XLEN-1:0]      pc_plus4_d,
  input  logic [XLEN-1:0]      imm_d,
  input  ctrl_t                ctrl_d,
  input  logic [REG_IDX_W-1:0] rd_w,
  input  logic [XLEN-1:0]      result_w,
  input  logic                 reg_write_w,
  output logic [XLEN-1:0]      rd1_e,
  output logic [XLEN-1:0]      rd2_e,
  output logic [XLEN-1:0]      pc_e,
  output logic [XLEN-1:0]      pc_plus4_e,
  output logic [XLEN-1:0]      imm_e,
  output logic [REG_IDX_W-1:0] rs1_e,
  output logic [REG_IDX_W-1:0] rs2_e,
  output logic [REG_IDX_W-1:0] rd_e,
  output ctrl_t                ctrl_e,
  output logic                 valid_e,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic [CNT_W-1:0]     bubble_cnt
);

  logic [XLEN-1:0]      rd1_e_q, rd1_e_d, rd2_e_q, rd2_e_d;
  logic [XLEN-1:0]      pc_e_q, pc_e_d, pc4_e_q, pc4_e_d, imm_e_q, imm_e_d;
  logic [REG_IDX_W-1:0] rs1_e_q, rs1_e_d, rs2_e_q, rs2_e_d, rd_e_q, rd_e_d;
  ctrl_t                ctrl_e_q, ctrl_e_d;
  logic                 valid_e_q, valid_e_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]      rd1_cap, rd2_cap;
  logic                 lu_hazard;
  logic                 bubble;

  hazard_detect u_hazard_detect (
    .valid_e_i      (valid_e_q),
    .result_src_e_i (ctrl_e_q.result_src),
    .rd_e_i         (rd_e_q),
    .rs1_d_i        (rs1_d),
    .rs2_d_i        (rs2_d),
    .lu_hazard_o    (lu_hazard),
    .stall_f_o      (stall_f),
    .stall_d_o      (stall_d)
  );

  // Operand values to capture, optionally overridden by the writeback result.
  always_comb begin
    rd1_cap = rd1_d;
    rd2_cap = rd2_d;
`ifdef WB_BYPASS_EN
    if (reg_write_w && (rd_w != '0) && (rd_w == rs1_d)) rd1_cap = result_w;
    if (reg_write_w && (rd_w != '0) && (rd_w == rs2_d)) rd2_cap = result_w;
`endif
  end

`ifndef WB_BYPASS_EN
  // Writeback port is only consumed by the bypass build.
  logic unused_wb;
  assign unused_wb = ^{rd_w, result_w, reg_write_w};
`endif

  // Flush and hazard collapse into a single bubble.
  assign bubble = flush_i | lu_hazard;

  // Next-state: bubble keeps data fields, clears control; else capture decode.
  always_comb begin
    rd1_e_d   = rd1_e_q;
    rd2_e_d   = rd2_e_q;
    pc_e_d    = pc_e_q;
    pc4_e_d   = pc4_e_q;
    imm_e_d   = imm_e_q;
    rs1_e_d   = rs1_e_q;
    rs2_e_d   = rs2_e_q;
    rd_e_d    = rd_e_q;
    ctrl_e_d  = ctrl_e_q;
    valid_e_d = valid_e_q;
    cnt_d     = cnt_q;
    if (bubble) begin
      ctrl_e_d  = CTRL_NOP;
      valid_e_d = 1'b0;
      rd_e_d    = '0;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      rd1_e_d   = rd1_cap;
      rd2_e_d   = rd2_cap;
      pc_e_d    = pc_d;
      pc4_e_d   = pc_plus4_d;
      imm_e_d   = imm_d;
      rs1_e_d   = rs1_d;
      rs2_e_d   = rs2_d;
      rd_e_d    = rd_d;
      ctrl_e_d  = ctrl_d;
      valid_e_d = 1'b1;
    end
  end

  // EX-stage register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_e_q   <= '0;
      rd2_e_q   <= '0;
      pc_e_q    <= '0;
      pc4_e_q   <= '0;
      imm_e_q   <= '0;
      rs1_e_q   <= '0;
      rs2_e_q   <= '0;
      rd_e_q    <= '0;
      ctrl_e_q  <= CTRL_NOP;
      valid_e_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      rd1_e_q   <= rd1_e_d;
      rd2_e_q   <= rd2_e_d;
      pc_e_q    <= pc_e_d;
      pc4_e_q   <= pc4_e_d;
      imm_e_q   <= imm_e_d;
      rs1_e_q   <= rs1_e_d;
      rs2_e_q   <= rs2_e_d;
      rd_e_q    <= rd_e_d;
      ctrl_e_q  <= ctrl_e_d;
      valid_e_q <= valid_e_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rd1_e      = rd1_e_q;
  assign rd2_e      = rd2_e_q;
  assign pc_e       = pc_e_q;
  assign pc_plus4_e = pc4_e_q;
  assign imm_e      = imm_e_q;
  assign rs1_e      = rs1_e_q;
  assign rs2_e      = rs2_e_q;
  assign rd_e       = rd_e_q;
  assign ctrl_e     = ctrl_e_q;
  assign valid_e    = valid_e_q;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the EX-stage contents.
module tb_id_ex_stage;
  import rv_pipe_pkg::*;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = 15;

  logic             clk, rst_n, flush_i;
  logic [XLEN-1:0]  rd1_d, rd2_d, pc_d, pc_plus4_d, imm_d, result_w;
  logic [4:0]       rs1_d, rs2_d, rd_d, rd_w;
  ctrl_t            ctrl_d, ctrl_e;
  logic             reg_write_w;
  logic [XLEN-1:0]  rd1_e, rd2_e, pc_e, pc_plus4_e, imm_e;
  logic [4:0]       rs1_e, rs2_e, rd_e;
  logic             valid_e, stall_f, stall_d;
  logic [CNT_W-1:0] bubble_cnt;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .imm_d(imm_d), .ctrl_d(ctrl_d),
    .rd_w(rd_w), .result_w(result_w), .reg_write_w(reg_write_w),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
    .imm_e(imm_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .ctrl_e(ctrl_e), .valid_e(valid_e), .stall_f(stall_f), .stall_d(stall_d),
    .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of what EX should hold.
  logic            m_valid;
  ctrl_t           m_ctrl;
  logic [XLEN-1:0] m_rd1, m_rd2, m_pc, m_pc4, m_imm;
  logic [4:0]      m_rs1, m_rs2, m_rd;
  int              m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic model_hz();
    return m_valid && (m_ctrl.result_src == RES_MEM) && (m_rd != 5'd0) &&
           ((m_rd == rs1_d) || (m_rd == rs2_d));
  endfunction

  function automatic logic [XLEN-1:0] operand(input logic [4:0] rs, input logic [XLEN-1:0] rf);
`ifdef WB_BYPASS_EN
    if (reg_write_w && rd_w != 5'd0 && rd_w == rs) return result_w;
`endif
    return rf;
  endfunction

  task automatic model_clear();
    m_valid = 1'b0; m_ctrl = CTRL_NOP; m_rd = '0; m_cnt = 0;
    m_rd1 = '0; m_rd2 = '0; m_pc = '0; m_pc4 = '0; m_imm = '0; m_rs1 = '0; m_rs2 = '0;
  endtask

  task automatic check_ex(input string tag);
    check({tag, ".valid"}, 64'(valid_e), 64'(m_valid));
    check({tag, ".ctrl"},  64'(ctrl_e),  64'(m_ctrl));
    check({tag, ".rd"},    64'(rd_e),    64'(m_rd));
    check({tag, ".cnt"},   64'(bubble_cnt), 64'(m_cnt));
    if (m_valid) begin
      check({tag, ".rd1"}, 64'(rd1_e), 64'(m_rd1));
      check({tag, ".rd2"}, 64'(rd2_e), 64'(m_rd2));
      check({tag, ".pc"},  64'(pc_e),  64'(m_pc));
      check({tag, ".pc4"}, 64'(pc_plus4_e), 64'(m_pc4));
      check({tag, ".imm"}, 64'(imm_e), 64'(m_imm));
      check({tag, ".rs1"}, 64'(rs1_e), 64'(m_rs1));
      check({tag, ".rs2"}, 64'(rs2_e), 64'(m_rs2));
    end
  endtask

  // One clock: check stalls before the edge, update the model, check EX after it.
  task automatic step(input string tag);
    logic hz;
    #1;
    hz = model_hz();
    check({tag, ".stall_f"}, 64'(stall_f), 64'(hz));
    check({tag, ".stall_d"}, 64'(stall_d), 64'(hz));
    @(posedge clk);
    if (flush_i || hz) begin
      m_valid = 1'b0; m_ctrl = CTRL_NOP; m_rd = '0;
      if (m_cnt < CNT_MAX) m_cnt++;
    end else begin
      m_valid = 1'b1; m_ctrl = ctrl_d; m_rd = rd_d;
      m_rd1 = operand(rs1_d, rd1_d); m_rd2 = operand(rs2_d, rd2_d);
      m_pc = pc_d; m_pc4 = pc_plus4_d; m_imm = imm_d; m_rs1 = rs1_d; m_rs2 = rs2_d;
    end
    #1;
    check_ex(tag);
  endtask

  task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [1:0] rsrc);
    rs1_d = rs1; rs2_d = rs2; rd_d = rd;
    ctrl_d = CTRL_NOP; ctrl_d.reg_write = 1'b1; ctrl_d.result_src = rsrc;
    ctrl_d.alu_ctrl = ALU_ADD;
    pc_d = $urandom; pc_plus4_d = pc_d + 32'd4; imm_d = $urandom;
    rd1_d = $urandom; rd2_d = $urandom;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd1;
      2:       return 5'd5;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; flush_i = 1'b0;
    rd1_d = '0; rd2_d = '0; pc_d = '0; pc_plus4_d = '0; imm_d = '0;
    rs1_d = '0; rs2_d = '0; rd_d = '0; ctrl_d = CTRL_NOP;
    rd_w = '0; result_w = '0; reg_write_w = 1'b0;
    model_clear();

    // Reset held for 3 cycles
    #1;
    check_ex("rst0");
    repeat (3) @(posedge clk);
    #1;
    check_ex("rst3");
    check("rst.stall_f", 64'(stall_f), 64'(0));
    rst_n = 1'b1;

    // Normal capture
    instr(5'd0, 5'd0, 5'd7, RES_ALU); rd1_d = 32'h5; rd2_d = 32'h8;
    step("cap");
    check("cap.rd1_e", 64'(rd1_e), 64'h5);
    check("cap.rd2_e", 64'(rd2_e), 64'h8);
    check("cap.rd_e", 64'(rd_e), 64'd7);
    check("cap.valid_e", 64'(valid_e), 64'd1);

    // Load followed by dependent instruction: exactly one bubble
    instr(5'd1, 5'd2, 5'd5, RES_MEM);
    step("ld");
    instr(5'd5, 5'd3, 5'd6, RES_ALU);
    #1;
    check("lu.stall_f", 64'(stall_f), 64'd1);
    step("lu");
    check("lu.valid_e", 64'(valid_e), 64'd0);
    check("lu.ctrl_e", 64'(ctrl_e), 64'(CTRL_NOP));
    check("lu.cnt", 64'(bubble_cnt), 64'd1);
    step("lu_rel");
    check("lu_rel.valid_e", 64'(valid_e), 64'd1);
    check("lu_rel.rd_e", 64'(rd_e), 64'd6);

    // Load to x0 never stalls; ALU producer never stalls
    instr(5'd1, 5'd2, 5'd0, RES_MEM);
    step("ldx0");
    instr(5'd0, 5'd0, 5'd1, RES_ALU);
    #1;
    check("x0.stall_f", 64'(stall_f), 64'd0);
    step("x0");
    instr(5'd1, 5'd2, 5'd5, RES_ALU);
    step("alu5");
    instr(5'd5, 5'd2, 5'd9, RES_ALU);
    #1;
    check("alu.stall_f", 64'(stall_f), 64'd0);
    step("alu");

    // Flush alone: bubble without stall
    instr(5'd3, 5'd4, 5'd8, RES_ALU); flush_i = 1'b1;
    #1;
    check("fl.stall_f", 64'(stall_f), 64'd0);
    step("fl");
    check("fl.cnt", 64'(bubble_cnt), 64'd2);
    check("fl.valid_e", 64'(valid_e), 64'd0);
    flush_i = 1'b0;

    // Flush coincident with load-use: single bubble
    instr(5'd1, 5'd2, 5'd5, RES_MEM);
    step("ld2");
    instr(5'd0, 5'd5, 5'd6, RES_ALU); flush_i = 1'b1;
    #1;
    check("flhz.stall_f", 64'(stall_f), 64'd1);
    step("flhz");
    check("flhz.cnt", 64'(bubble_cnt), 64'd3);
    flush_i = 1'b0;

    // Counter saturation
    flush_i = 1'b1;
    for (int i = 0; i < 20; i++) step("sat");
    check("sat.cnt", 64'(bubble_cnt), 64'd15);
    flush_i = 1'b0;

    // Writeback operand capture
    instr(5'd0, 5'd3, 5'd4, RES_ALU); rd2_d = 32'h0;
    rd_w = 5'd3; reg_write_w = 1'b1; result_w = 32'hDEAD;
    step("wb");
`ifdef WB_BYPASS_EN
    check("wb.rd2_e", 64'(rd2_e), 64'hDEAD);
`else
    check("wb.rd2_e", 64'(rd2_e), 64'h0);
`endif
    rd_w = 5'd0;
    step("wbx0");
    check("wbx0.rd2_e", 64'(rd2_e), 64'h0);
    reg_write_w = 1'b0;

    // Reset asserted during a stall clears everything at once
    instr(5'd1, 5'd2, 5'd5, RES_MEM);
    step("ld3");
    instr(5'd5, 5'd0, 5'd6, RES_ALU);
    #1;
    check("rstst.stall_pre", 64'(stall_f), 64'd1);
    rst_n = 1'b0;
    #1;
    model_clear();
    check("rstst.stall_f", 64'(stall_f), 64'd0);
    check("rstst.stall_d", 64'(stall_d), 64'd0);
    check_ex("rstst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      instr(pick_reg(), pick_reg(), pick_reg(), 2'($urandom_range(0, 2)));
      ctrl_d.mem_write = 1'($urandom); ctrl_d.jump = 1'($urandom);
      ctrl_d.branch = 1'($urandom); ctrl_d.alu_ctrl = 3'($urandom);
      ctrl_d.alu_src = 1'($urandom); ctrl_d.reg_write = 1'($urandom);
      flush_i = ($urandom_range(0, 5) == 0);
      rd_w = pick_reg(); reg_write_w = 1'($urandom); result_w = $urandom;
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage that sits directly downstream of the register file.
- Captures RD1/RD2, the decoded instruction fields and the control bundle into the EX-stage register on each rising clock edge.
- Detects load-use hazards and issues fetch/decode stall requests. Inserts bubbles on hazard or on a branch flush.
- Keeps a saturating count of inserted bubbles for performance debug.

Parameters:
- XLEN, 32, datapath width (operands, PC, immediate).
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush_i  in  1  branch/jump taken in EX; squash the instruction entering EX.
- rd1_d  in  XLEN  register file RD1 for rs1_d.
- rd2_d  in  XLEN  register file RD2 for rs2_d.
- rs1_d, rs2_d, rd_d  in  5 each  decoded register indices.
- pc_d, pc_plus4_d, imm_d  in  XLEN each  decode-stage PC, PC+4, extended immediate.
- ctrl_d  in  ctrl_t  packed control: reg_write, result_src[1:0], mem_write, jump, branch, alu_ctrl[2:0], alu_src.
- rd_w  in  5  writeback destination.
- result_w  in  XLEN  writeback data.
- reg_write_w  in  1  writeback enable.
- rd1_e, rd2_e, pc_e, pc_plus4_e, imm_e  out  XLEN each  EX-stage registered values.
- rs1_e, rs2_e, rd_e  out  5 each  EX-stage registered indices.
- ctrl_e  out  ctrl_t  EX-stage control.
- valid_e  out  1  EX holds a real instruction (0 = bubble).
- stall_f, stall_d  out  1 each  hold the PC and IF/ID registers.
- bubble_cnt  out  CNT_W  saturating count of bubbles inserted.

Behaviour:
- Reset (rst_n=0, asynchronous): all EX registers clear to 0, ctrl_e = CTRL_NOP (all fields 0), valid_e=0, bubble_cnt=0. stall_f/stall_d evaluate to 0 because valid_e=0.
- Load-use hazard (combinational): lu_hazard = valid_e & (ctrl_e.result_src==RES_MEM) & (rd_e!=0) & ((rd_e==rs1_d)|(rd_e==rs2_d)).
- Stall outputs: stall_f = stall_d = lu_hazard. They are not asserted for flush_i alone.
- Posedge update, priority order:
  1. If flush_i or lu_hazard: load a bubble. ctrl_e=CTRL_NOP, valid_e=0, rd_e=0. Data fields hold their previous values (don't-care). bubble_cnt increments.
  2. Otherwise: capture all *_d inputs. valid_e=1.
- Simultaneous flush_i and lu_hazard: exactly one bubble, and bubble_cnt increments by 1. stall outputs still follow lu_hazard.
- Latency: one cycle from decode inputs to *_e outputs. No backpressure other than lu_hazard.
- A load followed by a dependent instruction gives exactly one bubble. On the next cycle valid_e=0, so lu_hazard drops and decode re-presents the same instruction.
- rd_e==0 never raises a hazard (x0 destination).
- bubble_cnt saturates at 2^CNT_W-1 and does not wrap.
- Reset asserted mid-stall: outputs clear immediately. Stalls release in the same cycle.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: the stage captures writeback bypass data. rd1 captured = result_w when reg_write_w & (rd_w!=0) & (rd_w==rs1_d), else rd1_d. rd2 is handled the same way with rs2_d. Required if the register file is moved to rising-edge write.
- Undefined: rd1_d/rd2_d are captured unmodified. This relies on the register file's falling-edge write making the WB value visible before the rising edge.

Decomposition:
- Shared package rv_pipe_pkg holds:
  - ctrl_t packed struct.
  - CTRL_NOP constant.
  - result_src encodings RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10.
  - alu_ctrl encodings.
- One natural sub-module: hazard_detect, which computes lu_hazard and the stall outputs combinationally. The register and counter logic stays in id_ex_stage.

Test Plan:
- Reset then normal capture: rst_n low 3 cycles → all outputs 0 and valid_e=0. Release rst_n, drive rd1_d=32'h5, rd2_d=32'h8, rd_d=7, ctrl_d.reg_write=1 → next edge rd1_e=5, rd2_e=8, rd_e=7, valid_e=1.
- Load-use: EX holds a load with rd_e=5; decode presents rs1_d=5 → stall_f=stall_d=1 that cycle. Next edge: valid_e=0, ctrl_e=CTRL_NOP, bubble_cnt=1. Following edge: the dependent instruction is captured with valid_e=1.
- No hazard on x0 or ALU producer: a load with rd_e=0 and rs1_d=0 → no stall. An ALU op with rd_e=5 and rs1_d=5 → no stall.
- Flush: flush_i=1 with a valid decode instruction → bubble, stall_f=0, bubble_cnt +1. Flush coincident with a load-use hazard → single bubble, count +1.
- Counter saturation: with CNT_W=4, force 20 consecutive flushes → bubble_cnt stops at 15.
- WB_BYPASS_EN defined: rd_w=3, reg_write_w=1, result_w=32'hDEAD, rs2_d=3, rd2_d=32'h0 → rd2_e=32'hDEAD. With rd_w=0 → rd2_e=32'h0.
